// File: rtl/add_sub_seq_if.sv
// Operand/result stream bundle for add_sub_seq.
// The master side offers operands and consumes results.
// The slave side is the arithmetic unit.
interface add_sub_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, control, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, control, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/add_sub_seq.sv
// Multi-cycle add/subtract unit. It processes one CHUNK-bit limb per cycle,
// starting with the LSB limb, and keeps the carry/borrow in a register
// between limbs.
// Optional feature macro: ADD_SUB_SAT_EN. When it is defined, a result with
// signed overflow is replaced by the signed saturation value.
module add_sub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic          clk,
  input  logic          rst,
  add_sub_seq_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef ADD_SUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             add_q, add_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic [CHUNK-1:0] a_limb;
  logic [CHUNK-1:0] b_limb;
  logic [CHUNK:0]   limb_ext;
  logic [WIDTH-1:0] res_wrap;
  logic             ovf;

  // Limb datapath: the top bit of limb_ext is the carry (add) or the borrow (sub).
  always_comb begin
    a_limb = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_limb = b_q[int'(idx_q)*CHUNK +: CHUNK];
    if (add_q) begin
      limb_ext = {1'b0, a_limb} + {1'b0, b_limb} + {{CHUNK{1'b0}}, carry_q};
    end else begin
      limb_ext = {1'b0, a_limb} - {1'b0, b_limb} - {{CHUNK{1'b0}}, carry_q};
    end
    res_wrap = result_q;
    res_wrap[int'(idx_q)*CHUNK +: CHUNK] = limb_ext[CHUNK-1:0];
    // Only meaningful on the last limb, when res_wrap holds the complete result.
    if (add_q) begin
      ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_wrap[WIDTH-1] != a_q[WIDTH-1]);
    end else begin
      ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_wrap[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  // Control FSM: accept in IDLE, ripple the limbs in BUSY, hold the result in DONE.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    add_d       = add_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          add_d   = bus.control;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        result_d = res_wrap;
        carry_d  = limb_ext[CHUNK];
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          carry_out_d = limb_ext[CHUNK];
          overflow_d  = ovf;
`ifdef ADD_SUB_SAT_EN
          if (ovf) begin
            result_d = a_q[WIDTH-1] ? SAT_NEG : SAT_POS;
          end
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      add_q       <= 1'b0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      add_q       <= add_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_add_sub_seq.sv
// Scoreboard bench for add_sub_seq.
// dut0 is built with WIDTH=16, CHUNK=8; dut1 is built with WIDTH=32, CHUNK=4.
module tb_add_sub_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_sub_seq_if #(.WIDTH(16)) bus0 ();
  add_sub_seq_if #(.WIDTH(32)) bus1 ();

  add_sub_seq #(.WIDTH(16), .CHUNK(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  add_sub_seq #(.WIDTH(32), .CHUNK(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

`ifdef ADD_SUB_SAT_EN
  localparam logic [15:0] EXP_ADD_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_SUB_OVF = 16'h8000;
  localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] EXP_ADD_OVF = 16'h8000;
  localparam logic [15:0] EXP_SUB_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_OVF = 16'h0000;
`endif

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitors: compare each completed result handshake against the scoreboard head.
  exp_t e0;
  always @(negedge clk) begin
    if (!rst && bus0.out_valid && bus0.out_ready) begin
      if (q0.size() == 0) begin
        check("dut0 unexpected result", 32'd1, 32'd0);
      end else begin
        e0 = q0.pop_front();
        $display("dut0 txn result=0x%04h carry=%0b ovf=%0b", bus0.result, bus0.carry_out, bus0.overflow);
        check("dut0 result", {16'h0, bus0.result}, e0.r);
        check("dut0 carry_out", {31'h0, bus0.carry_out}, {31'h0, e0.c});
        check("dut0 overflow", {31'h0, bus0.overflow}, {31'h0, e0.o});
      end
    end
  end

  exp_t e1;
  always @(negedge clk) begin
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected result", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        $display("dut1 txn result=0x%08h carry=%0b ovf=%0b", bus1.result, bus1.carry_out, bus1.overflow);
        check("dut1 result", bus1.result, e1.r);
        check("dut1 carry_out", {31'h0, bus1.carry_out}, {31'h0, e1.c});
        check("dut1 overflow", {31'h0, bus1.overflow}, {31'h0, e1.o});
      end
    end
  end

  // One complete job on dut0 with out_ready held high.
  task automatic job0(input string name, input logic [15:0] av, input logic [15:0] bv,
                      input logic ctl, input logic [15:0] er, input logic ec, input logic eo);
    int n;
    n = 0;
    while (!bus0.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check({name, " in_ready before accept"}, {31'h0, bus0.in_ready}, 32'd1);
    q0.push_back('{r: {16'h0, er}, c: ec, o: eo});
    bus0.a = av; bus0.b = bv; bus0.control = ctl; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble the inputs after acceptance; they must have no effect.
    bus0.in_valid = 1'b0; bus0.a = 16'(~av); bus0.b = 16'(~bv); bus0.control = ~ctl;
    n = 0;
    while (!bus0.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check({name, " latency"}, n, 32'd2);
    @(posedge clk); #1;
    check({name, " in_ready after handshake"}, {31'h0, bus0.in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    bus0.in_valid = 0; bus0.a = 0; bus0.b = 0; bus0.control = 0; bus0.out_ready = 1;
    bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.control = 0; bus1.out_ready = 1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset in_ready", {31'h0, bus0.in_ready}, 32'd1);
    check("reset out_valid", {31'h0, bus0.out_valid}, 32'd0);
    check("reset result", {16'h0, bus0.result}, 32'd0);
    check("reset carry_out", {31'h0, bus0.carry_out}, 32'd0);
    check("reset overflow", {31'h0, bus0.overflow}, 32'd0);
    check("reset dut1 in_ready", {31'h0, bus1.in_ready}, 32'd1);

    job0("add carry", 16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0, 1'b0);
    job0("sub borrow", 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0);
    job0("sub underflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    job0("add wrap", 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0);
    job0("add ovf", 16'h7FFF, 16'h0001, 1'b1, EXP_ADD_OVF, 1'b0, 1'b1);
    job0("sub ovf", 16'h8000, 16'h0001, 1'b0, EXP_SUB_OVF, 1'b0, 1'b1);

    // Backpressure: 0x8000 + 0x8000 overflows negative with a carry.
    bus0.out_ready = 1'b0;
    q0.push_back('{r: {16'h0, EXP_NEG_OVF}, c: 1'b1, o: 1'b1});
    bus0.a = 16'h8000; bus0.b = 16'h8000; bus0.control = 1'b1; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    n = 0;
    while (!bus0.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp latency", n, 32'd2);
    for (int i = 0; i < 5; i++) begin
      bus0.in_valid = (i % 2 == 0);
      bus0.a = 16'($urandom); bus0.b = 16'($urandom); bus0.control = 1'($urandom);
      @(posedge clk); #1;
      check("bp result stable", {16'h0, bus0.result}, {16'h0, EXP_NEG_OVF});
      check("bp carry/ovf stable", {30'h0, bus0.carry_out, bus0.overflow}, 32'd3);
      check("bp in_ready low", {31'h0, bus0.in_ready}, 32'd0);
      check("bp out_valid held", {31'h0, bus0.out_valid}, 32'd1);
    end
    bus0.in_valid = 1'b0;
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp in_ready after release", {31'h0, bus0.in_ready}, 32'd1);
    check("bp out_valid after release", {31'h0, bus0.out_valid}, 32'd0);
    repeat (3) @(posedge clk); #1;
    check("bp no phantom job", {31'h0, bus0.out_valid}, 32'd0);

    // Reset after limb 0: this job must never be presented.
    bus0.a = 16'hAAAA; bus0.b = 16'h5555; bus0.control = 1'b1; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst mid in_ready", {31'h0, bus0.in_ready}, 32'd1);
    check("rst mid out_valid", {31'h0, bus0.out_valid}, 32'd0);
    check("rst mid result", {16'h0, bus0.result}, 32'd0);
    check("rst mid flags", {30'h0, bus0.carry_out, bus0.overflow}, 32'd0);
    repeat (4) @(posedge clk); #1;
    check("rst mid no result", {31'h0, bus0.out_valid}, 32'd0);
    job0("after reset", 16'h1234, 16'h1111, 1'b1, 16'h2345, 1'b0, 1'b0);

    // WIDTH=32, CHUNK=4: eight limbs of latency.
    q1.push_back('{r: 32'h0000_0000, c: 1'b1, o: 1'b0});
    bus1.a = 32'hFFFF_FFFF; bus1.b = 32'h0000_0001; bus1.control = 1'b1; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0; bus1.a = 32'h0; bus1.b = 32'h0;
    n = 0;
    while (!bus1.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("w32 latency", n, 32'd8);
    @(posedge clk); #1;
    check("w32 in_ready after handshake", {31'h0, bus1.in_ready}, 32'd1);

    repeat (2) @(posedge clk); #1;
    check("dut0 scoreboard drained", q0.size(), 32'd0);
    check("dut1 scoreboard drained", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, checks);
    $fatal(1);
  end
endmodule
